reg_file_64: RTL



---
 rtl/legv8_pkg.sv | 17 +
 rtl/rf_ram.sv | 44 ++++
 rtl/reg_file_64.sv | 116 +++++++++++
 3 files changed

// File: rtl/legv8_pkg.sv
// legv8_pkg
// Shared definitions for the LEGv8 single-cycle datapath register file.
//   RF_DATA_WIDTH / RF_ADDR_WIDTH : default register width and index width
//   XZR_IDX                       : index of the hardwired zero register
//   rf_state_t                    : register file FSM states (INIT sweep, RUN)
package legv8_pkg;

   localparam int RF_DATA_WIDTH = 64;
   localparam int RF_ADDR_WIDTH = 5;
   localparam int XZR_IDX       = 31;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } rf_state_t;

endpackage

// File: rtl/rf_ram.sv
// rf_ram
// Storage for the architectural registers X0..X30 (XZR is not stored).
// One synchronous write port and three asynchronous read ports; no reset,
// so the array can map onto distributed/LUT RAM.
// Ports:
//   clk    : clock, write happens on the rising edge
//   we     : write enable
//   waddr  : write index (indices >= DEPTH are dropped)
//   wdata  : write value
//   raddr  : three read indices, packed [port]
//   rdata  : three read values, packed [port]; indices >= DEPTH read 0
module rf_ram
   import legv8_pkg::*;
#(
   parameter int DATA_WIDTH = RF_DATA_WIDTH,
   parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
   input  logic                       clk,
   input  logic                       we,
   input  logic [ADDR_WIDTH-1:0]      waddr,
   input  logic [DATA_WIDTH-1:0]      wdata,
   input  logic [2:0][ADDR_WIDTH-1:0] raddr,
   output logic [2:0][DATA_WIDTH-1:0] rdata
);

   // The top index is the zero register and has no backing storage.
   localparam int DEPTH = (2 ** ADDR_WIDTH) - 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we && (waddr <= LAST_IDX)) begin
         mem[waddr] <= wdata;
      end
   end

   // Out-of-range indices are guarded here so the array is never read past
   // its end.
   for (genvar gi = 0; gi < 3; gi++) begin : g_rd
      assign rdata[gi] = (raddr[gi] <= LAST_IDX) ? mem[raddr[gi]] : '0;
   end

endmodule

// File: rtl/reg_file_64.sv
// reg_file_64
// 64-bit x 32-entry register file for the LEGv8 single-cycle datapath.
// X31 reads as zero (XZR) and writes to it are discarded. After reset an
// INIT sweep writes zero to X0..X30, one entry per edge, so the storage
// needs no reset tree; ready rises once the sweep is done.
// Ports:
//   clk, reset           : clock and synchronous active-high reset
//   read_reg1/read_data1 : combinational read port 1 (ALU R1)
//   read_reg2/read_data2 : combinational read port 2 (ALU R2)
//   reg_write, write_reg,
//   write_data           : write-back port, committed on the rising edge
//   dbg_addr/dbg_data    : registered debug read port
//   ready                : 1 once the clear sweep has completed
module reg_file_64
   import legv8_pkg::*;
#(
   parameter int DATA_WIDTH = RF_DATA_WIDTH,
   parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] read_reg1,
   input  logic [ADDR_WIDTH-1:0] read_reg2,
   output logic [DATA_WIDTH-1:0] read_data1,
   output logic [DATA_WIDTH-1:0] read_data2,
   input  logic                  reg_write,
   input  logic [ADDR_WIDTH-1:0] write_reg,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic [ADDR_WIDTH-1:0] dbg_addr,
   output logic [DATA_WIDTH-1:0] dbg_data,
   output logic                  ready
);

   localparam logic [ADDR_WIDTH-1:0] XZR      = ADDR_WIDTH'(XZR_IDX);
   localparam logic [ADDR_WIDTH-1:0] LAST_CLR = ADDR_WIDTH'(XZR_IDX - 1);

   rf_state_t             state_reg, state_next;
   logic [ADDR_WIDTH-1:0] clr_idx_reg, clr_idx_next;
   logic [DATA_WIDTH-1:0] dbg_data_reg, dbg_data_next;

   logic                       ram_we;
   logic [ADDR_WIDTH-1:0]      ram_waddr;
   logic [DATA_WIDTH-1:0]      ram_wdata;
   logic [2:0][ADDR_WIDTH-1:0] ram_raddr;
   logic [2:0][DATA_WIDTH-1:0] ram_rdata;
   logic [2:0][DATA_WIDTH-1:0] rd_masked;

   rf_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

   assign ram_raddr[0] = read_reg1;
   assign ram_raddr[1] = read_reg2;
   assign ram_raddr[2] = dbg_addr;

   // XZR and the whole INIT phase read as zero on every port. No
   // write-to-read bypass: the write-back value is derived from these reads.
   for (genvar gi = 0; gi < 3; gi++) begin : g_mask
      assign rd_masked[gi] = ((state_reg == INIT) || (ram_raddr[gi] == XZR))
                             ? '0 : ram_rdata[gi];
   end

   assign read_data1 = rd_masked[0];
   assign read_data2 = rd_masked[1];
   assign dbg_data   = dbg_data_reg;
   assign ready      = (state_reg == RUN);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= INIT;
         clr_idx_reg  <= '0;
         dbg_data_reg <= '0;
      end else begin
         state_reg    <= state_next;
         clr_idx_reg  <= clr_idx_next;
         dbg_data_reg <= dbg_data_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      clr_idx_next  = clr_idx_reg;
      dbg_data_next = rd_masked[2];
      ram_we        = 1'b0;
      ram_waddr     = write_reg;
      ram_wdata     = write_data;

      case (state_reg)
         INIT: begin
            // The sweep owns the write port; reg_write is ignored here.
            ram_we       = !reset;
            ram_waddr    = clr_idx_reg;
            ram_wdata    = '0;
            clr_idx_next = clr_idx_reg + 1'b1;
            if (clr_idx_reg == LAST_CLR) begin
               state_next = RUN;
            end
         end
         RUN: begin
            ram_we = reg_write && (write_reg != XZR) && !reset;
         end
         default: begin
            state_next = INIT;
         end
      endcase
   end

endmodule
